// File: rtl/nla_job_scheduler_if.sv
// Request/response bus between the NLA requesters and the job scheduler.
// Signal names keep the scheduler-side direction suffixes so the bus reads
// the same as the scheduler's own port list.
interface nla_job_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 16
);
    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   req_valid_i;
    logic [2*NUM_REQ-1:0] req_func_i;
    logic [NUM_REQ-1:0]   req_ready_o;
    logic                 rsp_valid_o;
    logic [IDW-1:0]       rsp_id_o;
    logic [DATA_W-1:0]    rsp_data_o;
    logic                 rsp_timeout_o;
    logic                 rsp_ready_i;

    // Requester / response-consumer side
    modport master (
        output req_valid_i, req_func_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_id_o, rsp_data_o, rsp_timeout_o
    );

    // Scheduler side
    modport slave (
        input  req_valid_i, req_func_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_id_o, rsp_data_o, rsp_timeout_o
    );
endinterface

// File: rtl/nla_job_scheduler.sv
// Round-robin job scheduler sharing one NLA polynomial engine between
// NUM_REQ requesters. Each job looks up its coefficient count, launches the
// engine, waits for the result strobe (or a watchdog abort) and returns the
// tagged response.
module nla_job_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_LINES = 5,
    parameter int DATA_W     = 16,
    parameter int TIMEOUT    = 511
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    nla_job_scheduler_if.slave    bus,
    input  logic                  cfg_we_i,
    input  logic [1:0]            cfg_func_i,
    input  logic [ADDR_LINES-1:0] cfg_count_i,
    output logic                  eng_start_o,
    output logic [ADDR_LINES-1:0] eng_coeff_count_o,
    input  logic                  eng_done_i,
    input  logic [DATA_W-1:0]     eng_result_i,
    output logic                  busy_o
);
    localparam int IDW = $clog2(NUM_REQ);

    localparam logic [3:0] S_IDLE   = 4'b0001;
    localparam logic [3:0] S_LAUNCH = 4'b0010;
    localparam logic [3:0] S_WAIT   = 4'b0100;
    localparam logic [3:0] S_RESP   = 4'b1000;

    logic [3:0]            state;
    logic [IDW-1:0]        ptr;
    logic [IDW-1:0]        id_q;
    logic [ADDR_LINES-1:0] count_q;
    logic [ADDR_LINES-1:0] cnt_tab [4];
    logic [9:0]            timer;
    logic [DATA_W-1:0]     res_q;
    logic                  to_q;

    logic                  gnt_any;
    logic [IDW-1:0]        gnt_id;
    logic [1:0]            gnt_func;
    logic [IDW:0]          idx;
    logic [NUM_REQ-1:0]    rdy;
    logic [IDW-1:0]        ptr_nxt;

    // Rotating-priority search: first valid requester at or after ptr, wrapping.
    always_comb begin
        gnt_any  = 1'b0;
        gnt_id   = '0;
        gnt_func = '0;
        idx      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, ptr} + (IDW+1)'(k);
            if (idx >= (IDW+1)'(NUM_REQ))
                idx = idx - (IDW+1)'(NUM_REQ);
            if (!gnt_any && bus.req_valid_i[idx[IDW-1:0]]) begin
                gnt_any  = 1'b1;
                gnt_id   = idx[IDW-1:0];
                gnt_func = bus.req_func_i[{idx[IDW-1:0], 1'b0} +: 2];
            end
        end
    end

    // One-hot accept pulse, only while idle; forced low while reset is held.
    always_comb begin
        rdy = '0;
        if (rstn_i && state == S_IDLE && gnt_any)
            rdy[gnt_id] = 1'b1;
    end

    assign ptr_nxt = (id_q == IDW'(NUM_REQ-1)) ? '0 : id_q + IDW'(1);

    // Coefficient-count table; writable in any state, read only at grant.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < 4; i++) cnt_tab[i] <= '0;
        end else if (cfg_we_i) begin
            cnt_tab[cfg_func_i] <= cfg_count_i;
        end
    end

    // Job FSM: grant, launch the engine, wait with watchdog, hold the response.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state   <= S_IDLE;
            ptr     <= '0;
            id_q    <= '0;
            count_q <= '0;
            timer   <= '0;
            res_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (gnt_any) begin
                        id_q    <= gnt_id;
                        count_q <= cnt_tab[gnt_func];
                        state   <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    timer <= 10'(TIMEOUT);
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // A done strobe beats a simultaneous watchdog expiry.
                    if (eng_done_i) begin
                        res_q <= eng_result_i;
                        to_q  <= 1'b0;
                        state <= S_RESP;
                    end else if (timer == '0) begin
                        res_q <= '0;
                        to_q  <= 1'b1;
                        state <= S_RESP;
                    end else begin
                        timer <= timer - 10'd1;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready_i) begin
                        ptr   <= ptr_nxt;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready_o   = rdy;
    assign bus.rsp_valid_o   = (state == S_RESP);
    assign bus.rsp_id_o      = id_q;
    assign bus.rsp_data_o    = res_q;
    assign bus.rsp_timeout_o = to_q;
    assign eng_start_o       = (state == S_LAUNCH);
    assign eng_coeff_count_o = (state == S_LAUNCH || state == S_WAIT) ? count_q : '0;
    assign busy_o            = (state != S_IDLE);
endmodule

// File: tb/tb_nla_job_scheduler.sv
// Scoreboard bench for nla_job_scheduler: a job-level model predicts grants,
// an engine model answers launches and queues expected responses, and a
// monitor pops and compares each response the scheduler presents.
module tb_nla_job_scheduler;
    localparam int NR = 4;
    localparam int AL = 5;
    localparam int DW = 16;
    localparam int TO = 511;

    typedef struct { int id; int cnt; } job_t;
    typedef struct { int id; int data; bit to; int cyc; } exp_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          cfg_we = 1'b0;
    logic [1:0]    cfg_func = '0;
    logic [AL-1:0] cfg_count = '0;
    logic          eng_start;
    logic [AL-1:0] eng_cc;
    logic          eng_done = 1'b0;
    logic [DW-1:0] eng_result = '0;
    logic          busy;

    nla_job_scheduler_if #(.NUM_REQ(NR), .DATA_W(DW)) bus();

    nla_job_scheduler #(.NUM_REQ(NR), .ADDR_LINES(AL), .DATA_W(DW), .TIMEOUT(TO)) u_dut (
        .clk_i(clk), .rstn_i(rstn), .bus(bus),
        .cfg_we_i(cfg_we), .cfg_func_i(cfg_func), .cfg_count_i(cfg_count),
        .eng_start_o(eng_start), .eng_coeff_count_o(eng_cc),
        .eng_done_i(eng_done), .eng_result_i(eng_result), .busy_o(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    function automatic void chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Job-level reference state
    job_t          jobq[$];
    exp_t          expq[$];
    int            grant_log[$];
    bit            m_busy = 0;
    int            m_ptr = 0;
    int            m_g;
    logic [AL-1:0] mtable[4];
    logic [NR-1:0] m_rdy;
    int            start_cyc = -10;
    bit            rel_valid = 0;
    int            rel_cyc, rel_ptr;
    logic [NR-1:0] acc_pend = '0;
    bit            hold_all = 0;
    int            eng_fix = -1;

    // Grant model: idle between a response handshake and the next grant
    initial forever begin
        @(negedge clk);
        if (!rstn) begin
            m_busy = 0; m_ptr = 0; rel_valid = 0; start_cyc = -10;
            for (int i = 0; i < 4; i++) mtable[i] = '0;
            jobq.delete(); expq.delete();
        end else begin
            if (rel_valid && cyc >= rel_cyc) begin
                m_busy = 0; m_ptr = rel_ptr; rel_valid = 0;
            end
            m_rdy = '0; m_g = 0;
            if (!m_busy)
                for (int k = NR-1; k >= 0; k--)
                    if (bus.req_valid_i[(m_ptr + k) % NR]) m_g = (m_ptr + k) % NR;
            if (!m_busy && bus.req_valid_i != 0) m_rdy[m_g] = 1'b1;
            chk("grant", bus.req_ready_o, m_rdy);
            chk("busy", busy, m_busy);
            chk("start", eng_start, cyc == start_cyc);
            if (m_rdy != 0) begin
                m_busy = 1;
                jobq.push_back('{m_g, int'(mtable[bus.req_func_i[2*m_g +: 2]])});
                start_cyc = cyc + 1;
                grant_log.push_back(m_g);
                acc_pend |= m_rdy;
            end
            if (cfg_we) mtable[cfg_func] = cfg_count;
        end
    end

    // Engine model: done strobe 'lat' cycles after start; lat 0 means never
    int        e_cnt = 0;
    int        e_lat;
    bit        e_live;
    int        e_data;
    job_t      e_job;
    initial forever begin
        @(negedge clk);
        eng_done = 1'b0;
        if (!rstn) e_cnt = 0;
        else begin
            if (e_cnt > 0) begin
                e_cnt--;
                if (e_cnt == 0) begin
                    eng_done = 1'b1;
                    eng_result = DW'(e_data);
                    if (e_live) chk("cc_wait", eng_cc, e_job.cnt);
                end
            end
            if (eng_start) begin
                chk("start_job", jobq.size(), 1);
                if (jobq.size() > 0) begin
                    e_job = jobq.pop_front();
                    e_lat = (eng_fix >= 0) ? eng_fix : int'($urandom_range(1, 30));
                    e_data = int'($urandom_range(0, 65535));
                    chk("cc_start", eng_cc, e_job.cnt);
                    e_cnt = e_lat;
                    e_live = (e_lat >= 1 && e_lat <= TO + 1);
                    expq.push_back('{e_job.id, e_live ? e_data : 0, !e_live,
                                     e_live ? cyc + e_lat + 1 : cyc + TO + 2});
                end
            end
        end
    end

    // Response monitor / scoreboard
    bit   in_rsp = 0;
    exp_t e;
    initial forever begin
        @(negedge clk);
        if (!rstn) in_rsp = 0;
        else begin
            if (expq.size() > 0 && cyc == expq[0].cyc) chk("rsp_valid", bus.rsp_valid_o, 1);
            if (bus.rsp_valid_o) begin
                chk("rsp_pending", expq.size() > 0, 1);
                if (expq.size() > 0) begin
                    e = expq[0];
                    if (!in_rsp) chk("rsp_lat", cyc, e.cyc);
                    in_rsp = 1;
                    chk("rsp_id", bus.rsp_id_o, e.id);
                    chk("rsp_data", bus.rsp_data_o, e.data);
                    chk("rsp_timeout", bus.rsp_timeout_o, e.to);
                    if (bus.rsp_ready_i) begin
                        void'(expq.pop_front());
                        in_rsp = 0;
                        rel_cyc = cyc + 1; rel_ptr = (e.id + 1) % NR; rel_valid = 1;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
        if (!hold_all) bus.req_valid_i = bus.req_valid_i & ~acc_pend;
        acc_pend = '0;
    endtask

    task automatic raise(input int i, input int f);
        bus.req_valid_i[i] = 1'b1;
        bus.req_func_i[2*i +: 2] = 2'(f);
    endtask

    task automatic cfg_write(input int f, input int c);
        tick(); cfg_we = 1'b1; cfg_func = 2'(f); cfg_count = AL'(c);
        tick(); cfg_we = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while ((bus.req_valid_i != 0 || m_busy || expq.size() > 0) && n < max) begin
            tick(); n++;
        end
        if (n >= max) begin
            n_chk++; n_fail++;
            $display("FAIL drain: still busy after %0d cycles", max);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rstn = 1'b0; bus.req_valid_i = '0; cfg_we = 1'b0; acc_pend = '0;
        #1;
        chk("rst_ready", bus.req_ready_o, 0);
        chk("rst_rvalid", bus.rsp_valid_o, 0);
        chk("rst_rid", bus.rsp_id_o, 0);
        chk("rst_rdata", bus.rsp_data_o, 0);
        chk("rst_rto", bus.rsp_timeout_o, 0);
        chk("rst_start", eng_start, 0);
        chk("rst_cc", eng_cc, 0);
        chk("rst_busy", busy, 0);
        repeat (2) tick();
        rstn = 1'b1;
    endtask

    task automatic load_table();
        cfg_write(0, 3); cfg_write(1, 5); cfg_write(2, 0); cfg_write(3, 7);
    endtask

    int ord[5] = '{0, 1, 2, 3, 0};

    initial begin
        int n;
        bus.req_valid_i = '0; bus.req_func_i = '0; bus.rsp_ready_i = 1'b1;
        do_reset();

        // single job, count lookup and result return
        load_table();
        eng_fix = 20; grant_log.delete();
        tick(); raise(0, 1);
        wait_idle(200);
        chk("t1_ngrant", grant_log.size(), 1);

        // round-robin order with all requesters held valid
        do_reset(); load_table();
        eng_fix = -1; grant_log.delete(); hold_all = 1;
        tick();
        for (int i = 0; i < NR; i++) raise(i, int'($urandom_range(0, 3)));
        n = 0;
        while (grant_log.size() < 5 && n < 2000) begin tick(); n++; end
        hold_all = 0; bus.req_valid_i = '0;
        chk("t2_ngrant", grant_log.size() >= 5, 1);
        for (int k = 0; k < 5 && k < grant_log.size(); k++) chk("t2_order", grant_log[k], ord[k]);
        wait_idle(300);

        // watchdog abort, stray late done while the abort response is held
        eng_fix = 600;
        tick(); bus.rsp_ready_i = 1'b0; raise(2, 3);
        repeat (700) tick();
        bus.rsp_ready_i = 1'b1;
        wait_idle(100);
        eng_fix = 7;
        tick(); raise(3, 0);
        wait_idle(100);

        // response stalled for 10 cycles with another request pending
        eng_fix = 5;
        tick(); bus.rsp_ready_i = 1'b0; raise(1, 2);
        n = 0;
        while (!bus.rsp_valid_o && n < 100) begin tick(); n++; end
        chk("t4_rsp_seen", bus.rsp_valid_o, 1);
        raise(3, 1);
        repeat (10) tick();
        bus.rsp_ready_i = 1'b1;
        wait_idle(100);

        // table write in the grant cycle affects only the next job
        eng_fix = 4;
        tick(); raise(0, 1); cfg_we = 1'b1; cfg_func = 2'd1; cfg_count = AL'(9);
        tick(); cfg_we = 1'b0;
        wait_idle(100);
        tick(); raise(0, 1);
        wait_idle(100);

        // reset in the middle of WAIT
        eng_fix = 0;
        tick(); raise(1, 0);
        repeat (50) tick();
        do_reset();
        grant_log.delete(); eng_fix = 3;
        tick(); raise(2, 1); raise(0, 2);
        wait_idle(300);
        chk("t6_ngrant", grant_log.size(), 2);
        if (grant_log.size() > 0) chk("t6_first", grant_log[0], 0);

        // randomized traffic
        eng_fix = -1;
        for (int it = 0; it < 600; it++) begin
            tick();
            cfg_we = 1'b0;
            if ($urandom_range(0, 7) == 0) begin
                cfg_we = 1'b1; cfg_func = 2'($urandom_range(0, 3)); cfg_count = AL'($urandom_range(0, 31));
            end
            for (int i = 0; i < NR; i++)
                if (!bus.req_valid_i[i] && $urandom_range(0, 3) == 0) raise(i, int'($urandom_range(0, 3)));
            bus.rsp_ready_i = ($urandom_range(0, 3) != 0);
        end
        tick(); cfg_we = 1'b0; bus.rsp_ready_i = 1'b1;
        wait_idle(1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end
endmodule
